sdram_arbiter_68k: RTL and testbench

- Shares the single SDRAM controller port between the 68000 bus (fx68k) and the ESP32 SPI loader/OSD port.
- Replaces the static loader-mux with request/acknowledge arbitration, and generates DTACKn for the CPU.
- Sits between the CPU/SPI glue in the top level and the SDRAM controller, in the clk_cpu domain.
- Keeps the CPU stalled while the loader holds the bus.

---
 rtl/sdram_arb_pkg.sv | 18 +
 rtl/spi_req_latch.sv | 74 +++++++
 rtl/sdram_arbiter_68k.sv | 198 +++++++++++++++++++
 tb/tb_sdram_arbiter_68k.sv | 300 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sdram_arb_pkg.sv
// sdram_arb_pkg
// Shared definitions for the 68k/SPI SDRAM arbiter:
//   arb_state_t  - arbiter FSM states
//   BE_*         - byte-enable encodings {upper, lower}
package sdram_arb_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    CPU_ACC = 2'd1,
    SPI_ACC = 2'd2,
    CPU_END = 2'd3
  } arb_state_t;

  localparam logic [1:0] BE_WORD  = 2'b11;
  localparam logic [1:0] BE_UPPER = 2'b10;
  localparam logic [1:0] BE_LOWER = 2'b01;

endpackage

// File: rtl/spi_req_latch.sv
// spi_req_latch
// Holds one SPI word request from the ESP32 loader until the arbiter has
// served it.
// Ports:
//   clk, rst_n              clock, synchronous active-low reset
//   spi_req/we/addr/din/be  one-cycle request from the SPI side
//   take                    arbiter grants the request this cycle
//   done                    memory access for the request completes
//   pend                    request waiting for a grant (not yet taken)
//   req_we/addr/din/be      request fields to forward to the memory port
//   busy                    request held (pending or in service)
module spi_req_latch #(
  parameter int ADDR_BITS = 23
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 spi_req,
  input  logic                 spi_we,
  input  logic [ADDR_BITS-1:0] spi_addr,
  input  logic [15:0]          spi_din,
  input  logic [1:0]           spi_be,
  input  logic                 take,
  input  logic                 done,
  output logic                 pend,
  output logic                 req_we,
  output logic [ADDR_BITS-1:0] req_addr,
  output logic [15:0]          req_din,
  output logic [1:0]           req_be,
  output logic                 busy
);

  logic                 valid;
  logic                 in_svc;
  logic                 we_q;
  logic [ADDR_BITS-1:0] addr_q;
  logic [15:0]          din_q;
  logic [1:0]           be_q;
  logic                 accept;

  // A request arriving while nothing is held is visible to the arbiter in
  // the same cycle, so a requester reacting to spi_ack gets back-to-back
  // service instead of losing the slot to a waiting CPU cycle.
  assign accept   = spi_req & ~valid;
  assign pend     = (valid & ~in_svc) | accept;
  assign busy     = valid;
  assign req_we   = valid ? we_q   : spi_we;
  assign req_addr = valid ? addr_q : spi_addr;
  assign req_din  = valid ? din_q  : spi_din;
  assign req_be   = valid ? be_q   : spi_be;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      valid  <= 1'b0;
      in_svc <= 1'b0;
      we_q   <= 1'b0;
      addr_q <= '0;
      din_q  <= '0;
      be_q   <= '0;
    end else if (done) begin
      valid  <= 1'b0;
      in_svc <= 1'b0;
    end else begin
      if (accept) begin
        valid  <= 1'b1;
        we_q   <= spi_we;
        addr_q <= spi_addr;
        din_q  <= spi_din;
        be_q   <= spi_be;
      end
      if (take) in_svc <= 1'b1;
    end
  end

endmodule

// File: rtl/sdram_arbiter_68k.sv
// sdram_arbiter_68k
// Shares the single SDRAM controller port between the fx68k bus and the
// ESP32 SPI loader/OSD port, and generates DTACKn for the CPU (clk_cpu).
// Ports:
//   clk, rst_n          clk_cpu, synchronous active-low reset
//   cpu_*               68000 bus: strobes, address, data, DTACKn, BERRn
//   cpu_hold            loader holds the bus; CPU cycles wait-state
//   spi_*               SPI word port: one-cycle request, ack pulse, busy
//   mem_*               SDRAM controller port: req held until mem_ack
// Optional build macro SDRAM_ARB_TIMEOUT_EN: memory-ack watchdog that aborts
// an access after TIMEOUT_CYCLES (BERRn for the CPU, FFFF data for SPI).
module sdram_arbiter_68k #(
  parameter int ADDR_BITS      = 23,
  parameter int SPI_STARVE     = 4,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 cpu_as_n,
  input  logic                 cpu_rw,
  input  logic                 cpu_uds_n,
  input  logic                 cpu_lds_n,
  input  logic [ADDR_BITS-1:0] cpu_a,
  input  logic [15:0]          cpu_dout,
  output logic [15:0]          cpu_din,
  output logic                 cpu_dtack_n,
  output logic                 cpu_berr_n,
  input  logic                 cpu_hold,
  input  logic                 spi_req,
  input  logic                 spi_we,
  input  logic [ADDR_BITS-1:0] spi_addr,
  input  logic [15:0]          spi_din,
  input  logic [1:0]           spi_be,
  output logic [15:0]          spi_dout,
  output logic                 spi_ack,
  output logic                 spi_busy,
  output logic                 mem_req,
  output logic                 mem_we,
  output logic [ADDR_BITS-1:0] mem_addr,
  output logic [15:0]          mem_din,
  output logic [1:0]           mem_be,
  input  logic [15:0]          mem_dout,
  input  logic                 mem_ack
);
  import sdram_arb_pkg::*;

  localparam int              SW         = $clog2(SPI_STARVE + 1);
  localparam logic [SW-1:0]   STARVE_MAX = SW'(SPI_STARVE);

  arb_state_t           state;
  logic                 cpu_served;
  logic [SW-1:0]        starve_cnt;
  logic                 cpu_pend;
  logic                 spi_pend;
  logic                 grant_spi;
  logic                 grant_cpu;
  logic                 spi_done;
  logic                 tmo_hit;
  logic                 sq_we;
  logic [ADDR_BITS-1:0] sq_addr;
  logic [15:0]          sq_din;
  logic [1:0]           sq_be;

  // cpu_served stops a strobe held for many cycles from being served twice.
  assign cpu_pend  = ~cpu_as_n & ~(cpu_uds_n & cpu_lds_n) & ~cpu_served & ~cpu_hold;
  assign grant_spi = (state == IDLE) && spi_pend && (!cpu_pend || starve_cnt < STARVE_MAX);
  assign grant_cpu = (state == IDLE) && !grant_spi && cpu_pend;
  assign spi_done  = (state == SPI_ACC) && (mem_ack || tmo_hit);

  spi_req_latch #(.ADDR_BITS(ADDR_BITS)) u_spi_latch (
    .clk      (clk),
    .rst_n    (rst_n),
    .spi_req  (spi_req),
    .spi_we   (spi_we),
    .spi_addr (spi_addr),
    .spi_din  (spi_din),
    .spi_be   (spi_be),
    .take     (grant_spi),
    .done     (spi_done),
    .pend     (spi_pend),
    .req_we   (sq_we),
    .req_addr (sq_addr),
    .req_din  (sq_din),
    .req_be   (sq_be),
    .busy     (spi_busy)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state       <= IDLE;
      cpu_served  <= 1'b0;
      starve_cnt  <= '0;
      mem_req     <= 1'b0;
      mem_we      <= 1'b0;
      mem_addr    <= '0;
      mem_din     <= '0;
      mem_be      <= '0;
      cpu_din     <= '0;
      cpu_dtack_n <= 1'b1;
      spi_ack     <= 1'b0;
      spi_dout    <= '0;
    end else begin
      spi_ack <= 1'b0;
      if (cpu_as_n) cpu_served <= 1'b0;
      case (state)
        IDLE: begin
          // mem_* are registered at grant and frozen until the ack, so the
          // controller never sees live CPU or SPI bus values.
          if (grant_spi) begin
            mem_req  <= 1'b1;
            mem_we   <= sq_we;
            mem_addr <= sq_addr;
            mem_din  <= sq_din;
            mem_be   <= sq_be;
            state    <= SPI_ACC;
          end else if (grant_cpu) begin
            mem_req  <= 1'b1;
            mem_we   <= ~cpu_rw;
            mem_addr <= cpu_a;
            mem_din  <= cpu_dout;
            mem_be   <= ~{cpu_uds_n, cpu_lds_n};
            state    <= CPU_ACC;
          end
        end
        CPU_ACC: begin
          if (mem_ack) begin
            mem_req     <= 1'b0;
            cpu_din     <= mem_dout;
            cpu_dtack_n <= 1'b0;
            starve_cnt  <= '0;
            cpu_served  <= 1'b1;
            state       <= CPU_END;
          end else if (tmo_hit) begin
            mem_req    <= 1'b0;
            cpu_served <= 1'b1;
            state      <= CPU_END;
          end
        end
        SPI_ACC: begin
          if (spi_done) begin
            mem_req  <= 1'b0;
            spi_ack  <= 1'b1;
            spi_dout <= mem_ack ? mem_dout : 16'hFFFF;
            // Count SPI grants taken while the CPU waited; saturate so the
            // CPU wins the next contested decision.
            if (cpu_pend)
              starve_cnt <= (starve_cnt == STARVE_MAX) ? starve_cnt : starve_cnt + 1'b1;
            else
              starve_cnt <= '0;
            state <= IDLE;
          end
        end
        CPU_END: begin
          if (cpu_as_n) begin
            cpu_dtack_n <= 1'b1;
            state       <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef SDRAM_ARB_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

  logic [TW-1:0] tmo_cnt;

  // Counter restarts in every non-access state, so each grant gets a fresh
  // window of TIMEOUT_CYCLES cycles.
  assign tmo_hit = (state == CPU_ACC || state == SPI_ACC) && !mem_ack &&
                   (tmo_cnt == TW'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk) begin
    if (!rst_n || !(state == CPU_ACC || state == SPI_ACC))
      tmo_cnt <= '0;
    else
      tmo_cnt <= tmo_cnt + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (!rst_n)
      cpu_berr_n <= 1'b1;
    else if (state == CPU_ACC && tmo_hit)
      cpu_berr_n <= 1'b0;
    else if (state == CPU_END && cpu_as_n)
      cpu_berr_n <= 1'b1;
  end
`else
  logic unused_tmo_cfg;

  assign tmo_hit        = 1'b0;
  assign cpu_berr_n     = 1'b1;
  // Watchdog limit has no function without the watchdog.
  assign unused_tmo_cfg = |TIMEOUT_CYCLES;
`endif

endmodule

// File: tb/tb_sdram_arbiter_68k.sv
// tb_sdram_arbiter_68k
// Directed bench for sdram_arbiter_68k: a CPU vector table plus hand-written
// sequences for loader hold, SPI starvation limit, dropped SPI requests,
// reset mid-access and (with SDRAM_ARB_TIMEOUT_EN) the ack watchdog.
module tb_sdram_arbiter_68k;
  import sdram_arb_pkg::*;

  localparam int AB = 23;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          cpu_as_n, cpu_rw, cpu_uds_n, cpu_lds_n;
  logic [AB-1:0] cpu_a;
  logic [15:0]   cpu_dout, cpu_din;
  logic          cpu_dtack_n, cpu_berr_n, cpu_hold;
  logic          spi_req, spi_we;
  logic [AB-1:0] spi_addr;
  logic [15:0]   spi_din, spi_dout;
  logic [1:0]    spi_be;
  logic          spi_ack, spi_busy;
  logic          mem_req, mem_we;
  logic [AB-1:0] mem_addr;
  logic [15:0]   mem_din, mem_dout;
  logic [1:0]    mem_be;
  logic          mem_ack;

  always #5 clk = ~clk;

  sdram_arbiter_68k #(.ADDR_BITS(AB), .SPI_STARVE(4), .TIMEOUT_CYCLES(255)) dut (
    .clk(clk), .rst_n(rst_n),
    .cpu_as_n(cpu_as_n), .cpu_rw(cpu_rw), .cpu_uds_n(cpu_uds_n), .cpu_lds_n(cpu_lds_n),
    .cpu_a(cpu_a), .cpu_dout(cpu_dout), .cpu_din(cpu_din),
    .cpu_dtack_n(cpu_dtack_n), .cpu_berr_n(cpu_berr_n), .cpu_hold(cpu_hold),
    .spi_req(spi_req), .spi_we(spi_we), .spi_addr(spi_addr), .spi_din(spi_din),
    .spi_be(spi_be), .spi_dout(spi_dout), .spi_ack(spi_ack), .spi_busy(spi_busy),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_din(mem_din),
    .mem_be(mem_be), .mem_dout(mem_dout), .mem_ack(mem_ack)
  );

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Memory model: runs on the falling edge, acks after mem_lat rising edges.
  bit            mem_auto = 1'b0;
  int            mem_lat = 1;
  logic [15:0]   mem_rdata = 16'h0000;
  int            inject_req = 0;
  int            inject_done = 0;
  int            mem_cnt = 0;
  int            ack_cyc = 0;
  int            req_rises = 0;
  int            spi_acks = 0;
  logic          req_prev = 1'b0;
  logic [AB-1:0] grant_q[$];

  initial begin
    mem_ack  = 1'b0;
    mem_dout = 16'h0000;
    forever begin
      @(negedge clk);
      if (mem_ack) mem_ack = 1'b0;
      else if (inject_req != inject_done) begin
        inject_done++;
        mem_ack  = 1'b1;
        mem_dout = 16'h1357;
      end else if (mem_auto && mem_req) begin
        mem_cnt++;
        if (mem_cnt >= mem_lat) begin
          mem_cnt  = 0;
          mem_ack  = 1'b1;
          mem_dout = mem_rdata;
          ack_cyc  = cyc;
        end
      end
      if (mem_req && !req_prev) begin
        req_rises++;
        grant_q.push_back(mem_addr);
      end
      req_prev = mem_req;
      if (spi_ack) spi_acks++;
    end
  end

  // SPI feeder: issues spi_target requests, normally only while not busy.
  int            spi_target = 0;
  int            spi_issued = 0;
  int            spi_base_idx = 0;
  logic [AB-1:0] spi_base = '0;
  bit            spi_ignore_busy = 1'b0;

  initial begin
    spi_req = 1'b0; spi_we = 1'b0; spi_addr = '0; spi_din = '0; spi_be = '0;
    forever begin
      @(posedge clk);
      #2;
      if (spi_issued < spi_target && (spi_ignore_busy || !spi_busy)) begin
        spi_req  = 1'b1;
        spi_we   = 1'b1;
        spi_addr = spi_base + AB'(spi_issued - spi_base_idx);
        spi_din  = 16'hA000 + 16'(spi_issued);
        spi_be   = BE_WORD;
        spi_issued++;
      end else begin
        spi_req = 1'b0;
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, cycle %0d required < 50000", cyc);
    $fatal(1);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic wait_dtack(input int budget, input string name);
    int n = 0;
    while (cpu_dtack_n !== 1'b0 && n < budget) begin tick(); n++; end
    chk({name, "_dtack_seen"}, {31'd0, cpu_dtack_n}, 32'd0);
  endtask

  task automatic wait_acks(input int target, input int budget, input string name);
    int n = 0;
    while (spi_acks < target && n < budget) begin tick(); n++; end
    chk(name, spi_acks, target);
  endtask

  typedef struct {
    logic          rw;
    logic          uds_n;
    logic          lds_n;
    logic [AB-1:0] addr;
    logic [15:0]   dout;
    logic [15:0]   rdata;
    int            lat;
    logic          exp_we;
    logic [1:0]    exp_be;
  } vec_t;

  vec_t          vt[4];
  logic [AB-1:0] exp_g[10];
  int            rises0, acks0, q0, n;

  initial begin
    vt[0] = '{1'b1, 1'b0, 1'b0, 23'h000100, 16'h0000, 16'hBEEF, 5, 1'b0, BE_WORD};
    vt[1] = '{1'b0, 1'b0, 1'b1, 23'h000200, 16'h12AB, 16'h0000, 3, 1'b1, BE_UPPER};
    vt[2] = '{1'b0, 1'b1, 1'b0, 23'h7FFFFF, 16'h00CD, 16'h0001, 1, 1'b1, BE_LOWER};
    vt[3] = '{1'b1, 1'b1, 1'b0, 23'h000001, 16'h0000, 16'h5A5A, 2, 1'b0, BE_LOWER};

    rst_n = 1'b0; cpu_as_n = 1'b1; cpu_rw = 1'b1; cpu_uds_n = 1'b1; cpu_lds_n = 1'b1;
    cpu_a = '0; cpu_dout = '0; cpu_hold = 1'b0;
    repeat (3) tick();
    chk("rst_mem_req", mem_req, 0);
    chk("rst_mem_we", mem_we, 0);
    chk("rst_mem_addr", mem_addr, 0);
    chk("rst_mem_din", mem_din, 0);
    chk("rst_mem_be", mem_be, 0);
    chk("rst_dtack_n", cpu_dtack_n, 1);
    chk("rst_berr_n", cpu_berr_n, 1);
    chk("rst_cpu_din", cpu_din, 0);
    chk("rst_spi_ack", spi_ack, 0);
    chk("rst_spi_busy", spi_busy, 0);
    chk("rst_spi_dout", spi_dout, 0);
    rst_n = 1'b1;
    tick();

    // CPU cycle table
    for (int i = 0; i < 4; i++) begin
      mem_lat = vt[i].lat; mem_rdata = vt[i].rdata; mem_auto = 1'b1;
      rises0 = req_rises;
      cpu_rw = vt[i].rw; cpu_a = vt[i].addr; cpu_dout = vt[i].dout;
      cpu_uds_n = vt[i].uds_n; cpu_lds_n = vt[i].lds_n; cpu_as_n = 1'b0;
      tick();
      chk("vec_grant_req", mem_req, 1);
      chk("vec_mem_we", mem_we, vt[i].exp_we);
      chk("vec_mem_be", mem_be, vt[i].exp_be);
      chk("vec_mem_addr", mem_addr, vt[i].addr);
      chk("vec_mem_din", mem_din, vt[i].dout);
      cpu_dout = ~vt[i].dout;
      wait_dtack(50, "vec");
      chk("vec_dtack_after_ack", cyc, ack_cyc + 1);
      chk("vec_cpu_din", cpu_din, vt[i].rdata);
      chk("vec_req_dropped", mem_req, 0);
      chk("vec_din_registered", mem_din, vt[i].dout);
      repeat (20) tick();
      chk("vec_one_req_per_strobe", req_rises - rises0, 1);
      chk("vec_dtack_held", cpu_dtack_n, 0);
      cpu_as_n = 1'b1; cpu_uds_n = 1'b1; cpu_lds_n = 1'b1;
      tick();
      chk("vec_dtack_release", cpu_dtack_n, 1);
      tick();
    end

    // Loader hold: six SPI writes complete, CPU waits until hold drops
    mem_lat = 2; mem_rdata = 16'hC0DE;
    cpu_hold = 1'b1; cpu_rw = 1'b1; cpu_a = 23'h000300;
    cpu_uds_n = 1'b0; cpu_lds_n = 1'b0; cpu_as_n = 1'b0;
    acks0 = spi_acks; q0 = grant_q.size();
    spi_base = '0; spi_base_idx = spi_target; spi_target += 6;
    for (int k = 1; k <= 6; k++) begin
      wait_acks(acks0 + k, 40, "hold_spi_ack");
      chk("hold_dtack_high", cpu_dtack_n, 1);
    end
    for (int k = 0; k < 6; k++)
      chk("hold_grant_addr", (q0 + k < grant_q.size()) ? grant_q[q0 + k] : 23'h7FFFFF, k);
    repeat (5) tick();
    chk("hold_no_cpu_req", mem_req, 0);
    chk("hold_dtack_still_high", cpu_dtack_n, 1);
    cpu_hold = 1'b0;
    wait_dtack(40, "hold_release");
    chk("hold_cpu_din", cpu_din, 16'hC0DE);
    cpu_as_n = 1'b1; cpu_uds_n = 1'b1; cpu_lds_n = 1'b1;
    tick(); tick();

    // Starvation limit: SPI x4, CPU, SPI x4, CPU
    q0 = grant_q.size(); mem_lat = 2; mem_rdata = 16'h5555;
    spi_base = 23'h000100; spi_base_idx = spi_target; spi_target += 8;
    cpu_rw = 1'b1; cpu_a = 23'h007000; cpu_uds_n = 1'b0; cpu_lds_n = 1'b0; cpu_as_n = 1'b0;
    wait_dtack(200, "starve_cpu1");
    cpu_as_n = 1'b1;
    tick();
    cpu_as_n = 1'b0;
    wait_dtack(200, "starve_cpu2");
    cpu_as_n = 1'b1; cpu_uds_n = 1'b1; cpu_lds_n = 1'b1;
    tick(); tick();
    exp_g = '{23'h100, 23'h101, 23'h102, 23'h103, 23'h7000,
              23'h104, 23'h105, 23'h106, 23'h107, 23'h7000};
    chk("starve_grant_count", grant_q.size() - q0, 10);
    for (int k = 0; k < 10; k++)
      chk("starve_grant_order", (q0 + k < grant_q.size()) ? grant_q[q0 + k] : 23'h7FFFFF, exp_g[k]);

    // Request while busy is dropped
    rises0 = req_rises; acks0 = spi_acks; mem_auto = 1'b0;
    spi_base = 23'h000200; spi_base_idx = spi_target; spi_ignore_busy = 1'b1; spi_target += 2;
    repeat (6) tick();
    spi_ignore_busy = 1'b0;
    chk("drop_one_req", req_rises - rises0, 1);
    chk("drop_addr", mem_addr, 23'h000200);
    chk("drop_busy", spi_busy, 1);
    mem_rdata = 16'h4242; mem_auto = 1'b1;
    wait_acks(acks0 + 1, 20, "drop_ack");
    repeat (4) tick();
    chk("drop_spi_dout", spi_dout, 16'h4242);
    chk("drop_busy_clear", spi_busy, 0);
    chk("drop_still_one_req", req_rises - rises0, 1);
    chk("drop_one_ack", spi_acks - acks0, 1);

    // Reset in the middle of a CPU access, then a stray ack
    mem_auto = 1'b0; acks0 = spi_acks;
    cpu_rw = 1'b1; cpu_a = 23'h000400; cpu_uds_n = 1'b0; cpu_lds_n = 1'b0; cpu_as_n = 1'b0;
    tick();
    chk("rstmid_req_before", mem_req, 1);
    tick();
    rst_n = 1'b0; cpu_as_n = 1'b1; cpu_uds_n = 1'b1; cpu_lds_n = 1'b1;
    tick();
    chk("rstmid_req_dropped", mem_req, 0);
    chk("rstmid_dtack_n", cpu_dtack_n, 1);
    rst_n = 1'b1;
    inject_req++;
    repeat (3) tick();
    chk("late_ack_cpu_din", cpu_din, 0);
    chk("late_ack_dtack_n", cpu_dtack_n, 1);
    chk("late_ack_mem_req", mem_req, 0);
    chk("late_ack_no_spi_ack", spi_acks - acks0, 0);
    chk("late_ack_spi_dout", spi_dout, 0);

`ifdef SDRAM_ARB_TIMEOUT_EN
    cpu_rw = 1'b1; cpu_a = 23'h000500; cpu_uds_n = 1'b0; cpu_lds_n = 1'b0; cpu_as_n = 1'b0;
    tick();
    n = 0;
    while (cpu_berr_n !== 1'b0 && n < 400) begin tick(); n++; end
    chk("tmo_cycles", n, 255);
    chk("tmo_req_dropped", mem_req, 0);
    chk("tmo_dtack_high", cpu_dtack_n, 1);
    cpu_as_n = 1'b1; cpu_uds_n = 1'b1; cpu_lds_n = 1'b1;
    tick();
    chk("tmo_berr_release", cpu_berr_n, 1);
`else
    chk("berr_tied_high", cpu_berr_n, 1);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
